dram_arbiter: RTL

//  Shares the single dram port (rden/wren/addr/data/mem_ready) between the I-cache refill path and the
//  D-cache refill/writeback path. Sits between both cache_fsm instances and u_dram in the core top.

---
 rtl/cache_pkg.sv | 18 +
 rtl/dram_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cache_pkg.sv
// Shared types for the cache/memory subsystem.
//   arb_state_t : dram arbiter FSM states
//   req_id_t    : identifies which requester (I-cache or D-cache) last held the dram port
package cache_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IC,
    ARB_DC,
    ARB_DC_HOLD
  } arb_state_t;

  typedef enum logic {
    REQ_IC,
    REQ_DC
  } req_id_t;

endpackage

// File: rtl/dram_arbiter.sv
// Shares the single dram port between the I-cache refill path and the D-cache
// refill/writeback path. Round-robin on simultaneous requests, with a D-cache
// write->read lock so a dirty evict and its refill run back-to-back. A granted
// transaction always runs to mem_ready.
//
// Ports:
//   clk, rst                          core clock, synchronous active-low reset
//   ic_rden, ic_addr                  I-cache line read request (level until ic_ready)
//   ic_data_out, ic_ready             line and 1-cycle completion pulse to I-cache
//   dc_rden, dc_wren, dc_addr,        D-cache read / writeback request (level until dc_ready)
//   dc_data_in                        writeback line
//   dc_data_out, dc_ready             line and 1-cycle completion pulse to D-cache
//   mem_rden, mem_wren, mem_addr,     registered dram strobes, address and write data
//   mem_data_in
//   mem_data_out, mem_ready           dram read data and completion pulse
module dram_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned AWIDTH = 6,
  parameter int unsigned DWIDTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_rden,
  input  logic [AWIDTH-1:0] ic_addr,
  output logic [DWIDTH-1:0] ic_data_out,
  output logic              ic_ready,
  input  logic              dc_rden,
  input  logic              dc_wren,
  input  logic [AWIDTH-1:0] dc_addr,
  input  logic [DWIDTH-1:0] dc_data_in,
  output logic [DWIDTH-1:0] dc_data_out,
  output logic              dc_ready,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data_in,
  input  logic [DWIDTH-1:0] mem_data_out,
  input  logic              mem_ready
);

  arb_state_t        state_q, state_d;
  req_id_t           last_grant_q, last_grant_d;
  logic              mem_rden_q, mem_rden_d;
  logic              mem_wren_q, mem_wren_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_data_in_q, mem_data_in_d;

  logic dc_req;
  assign dc_req = dc_rden | dc_wren;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_rden_d    = mem_rden_q;
    mem_wren_d    = mem_wren_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;

    unique case (state_q)
      ARB_IDLE: begin
        // On a tie the side that did not go last wins.
        if (dc_req && (!ic_rden || last_grant_q == REQ_IC)) begin
          state_d       = ARB_DC;
          // Write wins if both D-cache strobes are high.
          mem_wren_d    = dc_wren;
          mem_rden_d    = ~dc_wren;
          mem_addr_d    = dc_addr;
          mem_data_in_d = dc_data_in;
        end else if (ic_rden) begin
          state_d    = ARB_IC;
          mem_rden_d = 1'b1;
          mem_wren_d = 1'b0;
          mem_addr_d = ic_addr;
        end
      end
      ARB_IC: begin
        if (mem_ready) begin
          state_d      = ARB_IDLE;
          mem_rden_d   = 1'b0;
          last_grant_d = REQ_IC;
        end
      end
      ARB_DC: begin
        if (mem_ready) begin
          mem_rden_d   = 1'b0;
          mem_wren_d   = 1'b0;
          last_grant_d = REQ_DC;
          // A finished writeback gets one cycle to present its refill read.
          state_d      = mem_wren_q ? ARB_DC_HOLD : ARB_IDLE;
        end
      end
      ARB_DC_HOLD: begin
        if (dc_rden) begin
          state_d    = ARB_DC;
          mem_rden_d = 1'b1;
          mem_wren_d = 1'b0;
          mem_addr_d = dc_addr;
        end else begin
          state_d      = ARB_IDLE;
          last_grant_d = REQ_DC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ARB_IDLE;
      last_grant_q  <= REQ_IC;
      mem_rden_q    <= 1'b0;
      mem_wren_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_rden_q    <= mem_rden_d;
      mem_wren_q    <= mem_wren_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign mem_rden    = mem_rden_q;
  assign mem_wren    = mem_wren_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;

  assign ic_ready    = mem_ready && (state_q == ARB_IC);
  assign dc_ready    = mem_ready && (state_q == ARB_DC);
  assign ic_data_out = mem_data_out;
  assign dc_data_out = mem_data_out;

endmodule
